// File: rtl/fdtd_pkg.sv
// Shared FDTD accelerator types: step-scheduler states and phase encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fdtd_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE_HY  = 3'd1,
        S_WAIT_HY   = 3'd2,
        S_ISSUE_EZ  = 3'd3,
        S_WAIT_EZ   = 3'd4,
        S_ISSUE_SRC = 3'd5,
        S_WAIT_SRC  = 3'd6,
        S_DONE      = 3'd7
    } fdtd_sched_state_t;

    // Phase encoding shared with fdtd_calc_ctrl and the memory controller.
    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_HY   = 2'd1;
    localparam logic [1:0] PH_EZ   = 2'd2;
    localparam logic [1:0] PH_SRC  = 2'd3;

    function automatic logic [1:0] sched_phase(input fdtd_sched_state_t s);
        case (s)
            S_ISSUE_HY, S_WAIT_HY:   return PH_HY;
            S_ISSUE_EZ, S_WAIT_EZ:   return PH_EZ;
            S_ISSUE_SRC, S_WAIT_SRC: return PH_SRC;
            default:                 return PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/fdtd_step_sched.sv
// Time-step scheduler: Hy, Ez, src phases per step for a programmed step count.
// Latency: flag one cycle after start accept / write-back-done; done one cycle after last write-back.
// Backpressure: each phase waits for wb_done_i; stop_i takes effect only at a phase boundary.
module fdtd_step_sched
    import fdtd_pkg::*;
#(
    parameter int unsigned TIME_STEPS     = 300,
    parameter int unsigned STEP_CNT_WIDTH = 16
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic [STEP_CNT_WIDTH-1:0] time_steps_i,
    input  logic                      wb_done_i,
    output logic                      calc_Hy_flg_o,
    output logic                      calc_Ez_flg_o,
    output logic                      calc_src_flg_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      aborted_o,
    output logic [STEP_CNT_WIDTH-1:0] step_cnt_o,
    output logic [1:0]                phase_o
);

    localparam logic [STEP_CNT_WIDTH-1:0] DEF_STEPS = STEP_CNT_WIDTH'(TIME_STEPS);

    fdtd_sched_state_t         state_q, state_d;
    logic [STEP_CNT_WIDTH-1:0] target_q, target_d;
    logic [STEP_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                      abort_q, abort_d;
    logic                      aborted_q, aborted_d;
    logic                      busy_st;
    logic                      abort_now;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            target_q  <= '0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            aborted_q <= aborted_d;
        end
    end

    assign busy_st   = (state_q != S_IDLE) && (state_q != S_DONE);
    // A stop arriving together with the closing write-back still ends the run there.
    assign abort_now = abort_q | stop_i;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        aborted_d = aborted_q;

        if (busy_st && stop_i) begin
            abort_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    target_d  = (time_steps_i == '0) ? DEF_STEPS : time_steps_i;
                    cnt_d     = '0;
                    abort_d   = 1'b0;
                    aborted_d = 1'b0;
                    state_d   = S_ISSUE_HY;
                end
            end
            S_ISSUE_HY:  state_d = S_WAIT_HY;
            S_ISSUE_EZ:  state_d = S_WAIT_EZ;
            S_ISSUE_SRC: state_d = S_WAIT_SRC;
            S_WAIT_HY, S_WAIT_EZ: begin
                if (wb_done_i) begin
                    if (abort_now) begin
                        aborted_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = (state_q == S_WAIT_HY) ? S_ISSUE_EZ : S_ISSUE_SRC;
                    end
                end
            end
            S_WAIT_SRC: begin
                if (wb_done_i) begin
                    // The source phase closes the step, so it counts even when aborting.
                    cnt_d = cnt_q + 1'b1;
                    if (abort_now) begin
                        aborted_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (cnt_d == target_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE_HY;
                    end
                end
            end
            S_DONE: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign calc_Hy_flg_o  = (state_q == S_ISSUE_HY);
    assign calc_Ez_flg_o  = (state_q == S_ISSUE_EZ);
    assign calc_src_flg_o = (state_q == S_ISSUE_SRC);
    assign busy_o         = busy_st;
    assign done_o         = (state_q == S_DONE);
    assign aborted_o      = aborted_q;
    assign step_cnt_o     = cnt_q;
    assign phase_o        = sched_phase(state_q);

endmodule

// File: tb/tb_fdtd_step_sched.sv
// Randomized bench for fdtd_step_sched: acts as the memory controller and
// predicts flags, step count and completion from the per-step phase sequence.
module tb_fdtd_step_sched;
    import fdtd_pkg::*;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         start_i;
    logic         stop_i;
    logic [W-1:0] time_steps_i;
    logic         wb_done_i;
    logic         calc_Hy_flg_o, calc_Ez_flg_o, calc_src_flg_o;
    logic         busy_o, done_o, aborted_o;
    logic [W-1:0] step_cnt_o;
    logic [1:0]   phase_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    fdtd_step_sched #(.TIME_STEPS(300), .STEP_CNT_WIDTH(W)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .time_steps_i   (time_steps_i),
        .wb_done_i      (wb_done_i),
        .calc_Hy_flg_o  (calc_Hy_flg_o),
        .calc_Ez_flg_o  (calc_Ez_flg_o),
        .calc_src_flg_o (calc_src_flg_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .aborted_o      (aborted_o),
        .step_cnt_o     (step_cnt_o),
        .phase_o        (phase_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] flags();
        return {29'd0, calc_Hy_flg_o, calc_Ez_flg_o, calc_src_flg_o};
    endfunction

    task automatic check_idle(input string tag, input int cnt, input bit ab);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_flags"}, flags(), 0);
        check({tag, "_phase"}, phase_o, PH_IDLE);
        check({tag, "_cnt"}, step_cnt_o, cnt);
        check({tag, "_aborted"}, aborted_o, ab);
    endtask

    // Runs one job. abort_idx selects the flag (0-based, three per step) during
    // whose phase stop_i is pulsed; -1 means run to completion.
    task automatic run(input int n, input int abort_idx, input bit spurious,
                       input bit pre_started, input bit chain, input int chain_n);
        int tgt, steps, f, p, d, stop_at;
        bit ab, fin;
        logic [31:0] exp_f;
        tgt = (n == 0) ? 300 : n;
        steps = 0; f = 0; ab = 0; fin = 0;
        if (!pre_started) begin
            time_steps_i = W'(n);
            start_i = 1'b1;
        end
        tick();
        start_i = 1'b0;
        check("start_cnt", step_cnt_o, 0);
        check("start_aborted", aborted_o, 0);
        while (!fin) begin
            p = f % 3;
            d = $urandom_range(1, 4);
            stop_at = (f == abort_idx) ? int'($urandom_range(0, d)) : -1;
            exp_f = 32'd4 >> p;
            check("flag", flags(), exp_f);
            check("phase", phase_o, p + 1);
            check("busy", busy_o, 1);
            check("done_early", done_o, 0);
            if (spurious && p == 0) wb_done_i = 1'b1;
            if (stop_at == 0) stop_i = 1'b1;
            tick();
            wb_done_i = 1'b0; stop_i = 1'b0;
            for (int i = 1; i <= d; i++) begin
                check("wait_flags", flags(), 0);
                check("wait_phase", phase_o, p + 1);
                check("wait_cnt", step_cnt_o, steps);
                if (spurious && p == 1 && i == 1) begin
                    start_i = 1'b1;
                    time_steps_i = W'(1);
                end
                if (i == stop_at) stop_i = 1'b1;
                if (i == d) wb_done_i = 1'b1;
                tick();
                wb_done_i = 1'b0; stop_i = 1'b0; start_i = 1'b0;
            end
            if (f == abort_idx) ab = 1;
            if (p == 2) steps++;
            fin = ab || (p == 2 && steps == tgt);
            f++;
        end
        check("done", done_o, 1);
        check("done_busy", busy_o, 0);
        check("done_flags", flags(), 0);
        check("done_cnt", step_cnt_o, steps);
        check("done_aborted", aborted_o, ab);
        if (!ab) check("done_cnt_tgt", step_cnt_o, tgt);
        if (chain) begin
            time_steps_i = W'(chain_n);
            start_i = 1'b1;
        end
        tick();
        check_idle("post", steps, ab);
    endtask

    initial begin
        int n, ai;
        RST_N = 1'b0;
        start_i = 1'b0; stop_i = 1'b0; wb_done_i = 1'b0; time_steps_i = '0;
        #12;
        check_idle("reset", 0, 0);
        RST_N = 1'b1;
        tick();
        wb_done_i = 1'b1; stop_i = 1'b1;
        tick();
        wb_done_i = 1'b0; stop_i = 1'b0;
        tick();
        check_idle("idle_spur", 0, 0);

        run(2, -1, 0, 0, 0, 0);
        run(0, -1, 0, 0, 0, 0);
        run(5, 7, 0, 0, 0, 0);
        run(3, -1, 1, 0, 0, 0);
        run(2, -1, 0, 0, 1, 3);
        run(3, -1, 0, 1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            n  = $urandom_range(1, 4);
            ai = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3 * n - 1)) : -1;
            run(n, ai, 1'($urandom_range(0, 1)), 0, 0, 0);
        end

        // Reset while waiting on the source write-back of step 1.
        time_steps_i = W'(2); start_i = 1'b1;
        tick(); start_i = 1'b0;
        tick(); wb_done_i = 1'b1;
        tick(); wb_done_i = 1'b0;
        check("rst_ez_flag", flags(), 2);
        tick(); wb_done_i = 1'b1;
        tick(); wb_done_i = 1'b0;
        check("rst_src_flag", flags(), 1);
        tick();
        check("rst_wait_phase", phase_o, PH_SRC);
        RST_N = 1'b0;
        #1;
        check_idle("rst_async", 0, 0);
        #3;
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_done_i = (i == 1);
            tick();
            check_idle("rst_release", 0, 0);
        end
        wb_done_i = 1'b0;
        run(1, -1, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fdtd_step_sched.md
# fdtd_step_sched

Time-step scheduler for the FDTD accelerator, directly upstream of `fdtd_calc_ctrl`. It runs the per-time-step sequence H-field update, E-field update, then source injection, for a programmable number of time steps. It issues one-cycle `calc_*_flg` pulses to the calculation controller and waits for the memory controller's write-back-done pulse before starting the next phase. It reports busy, progress and completion to the register interface.

## Interface
Parameters:
- `TIME_STEPS`, 300: step count used when `time_steps_i` is 0.
- `STEP_CNT_WIDTH`, 16: width of step counter and programmed count.

Ports:
- `CLK`, in, 1: single clock.
- `RST_N`, in, 1: asynchronous active-low reset.
- `start_i`, in, 1: run request pulse. Accepted only in IDLE.
- `stop_i`, in, 1: abort request pulse. Honoured at the next phase boundary.
- `time_steps_i`, in, `STEP_CNT_WIDTH`: steps to run. Sampled on start accept; 0 selects `TIME_STEPS`.
- `wb_done_i`, in, 1: one-cycle pulse from the memory controller. The current phase's buffer-to-data_mem write-back is complete.
- `calc_Hy_flg_o`, out, 1: one-cycle pulse that starts an Hy pass.
- `calc_Ez_flg_o`, out, 1: one-cycle pulse that starts an Ez pass.
- `calc_src_flg_o`, out, 1: one-cycle pulse that starts a source load.
- `busy_o`, out, 1: high from start accept until DONE.
- `done_o`, out, 1: one-cycle completion pulse.
- `aborted_o`, out, 1: sticky. The last run ended by `stop_i`.
- `step_cnt_o`, out, `STEP_CNT_WIDTH`: number of fully completed time steps.
- `phase_o`, out, 2: current phase. 0 = idle, 1 = Hy, 2 = Ez, 3 = src.

## Operation
- States: IDLE, ISSUE_HY, WAIT_HY, ISSUE_EZ, WAIT_EZ, ISSUE_SRC, WAIT_SRC, DONE.
- IDLE with `start_i` high:
  - latch target (`time_steps_i`, or `TIME_STEPS` if 0),
  - clear `step_cnt_o` and `aborted_o`,
  - go to ISSUE_HY.
- Each ISSUE_x state lasts exactly one cycle, then moves to WAIT_x.
- WAIT_x with `wb_done_i` high:
  - From WAIT_HY, go to ISSUE_EZ.
  - From WAIT_EZ, go to ISSUE_SRC.
  - From WAIT_SRC:
    - increment `step_cnt_o`;
    - if the incremented value equals the target, go to DONE;
    - otherwise go to ISSUE_HY.
- Abort:
  - `stop_i` in any busy state sets an internal abort latch.
  - At the next `wb_done_i` in any WAIT state, go to DONE and set `aborted_o`.
  - An in-flight phase is never abandoned, because `fdtd_calc_ctrl` cannot be cancelled.
  - `stop_i` in IDLE or DONE is ignored.
- DONE lasts one cycle, then returns to IDLE.
- `step_cnt_o` counts only completed steps. An abort in Hy or Ez leaves the partial step uncounted.
- `step_cnt_o` holds after DONE until the next accepted start.
- Target width equals counter width, so no wrap is possible. Maximum target is 2^`STEP_CNT_WIDTH` − 1.

## Timing
- All outputs are registered and decoded from current state.
- Reset values: all outputs 0, state IDLE, abort latch 0, target 0.
- `start_i` sampled high at edge k:
  - `busy_o` and `calc_Hy_flg_o` are high in cycle k+1;
  - `phase_o` = 1 from cycle k+1.
- `wb_done_i` sampled in WAIT_x at edge w: the next phase's flag pulses in cycle w+1.
  - Minimum spacing between consecutive flags is therefore 2 cycles.
- Final `wb_done_i` at edge w:
  - `done_o` high and `busy_o` low in cycle w+1;
  - `step_cnt_o` equals the target in cycle w+1.
- Flags are never asserted outside ISSUE states. At most one flag is high in any cycle.
- Inputs ignored by state:
  - `wb_done_i` outside WAIT states;
  - `start_i` outside IDLE, including DONE. No queuing.
- `stop_i` and `wb_done_i` in the same cycle in WAIT: abort takes effect immediately, DONE next cycle.
- Reset mid-run returns everything to reset values immediately (asynchronous). No flag is emitted on reset release.

## Structure
- Add to the shared `fdtd_pkg`:
  - the state enum `fdtd_sched_state_t`;
  - the phase encoding constants `PH_IDLE`, `PH_HY`, `PH_EZ`, `PH_SRC`.
  - `fdtd_calc_ctrl` and the memory controller reuse the phase encoding.
- Single flat module with no sub-module. Only the FSM, step counter, target register and abort latch are needed.

## Test plan
- Basic two-step run:
  - Stimulus: `time_steps_i` = 2, pulse `start_i`, return `wb_done_i` 5 cycles after each flag.
  - Expected: flags in order Hy, Ez, src, Hy, Ez, src. `step_cnt_o` goes 1 then 2. One `done_o` pulse one cycle after the 6th `wb_done_i`. `aborted_o` = 0.
- Default count:
  - Stimulus: `time_steps_i` = 0.
  - Expected: exactly 300 src flags, then `done_o` with `step_cnt_o` = 300.
- Abort in the Ez phase of step 3:
  - Stimulus: pulse `stop_i` in the Ez phase of step 3, then return `wb_done_i`.
  - Expected: no src flag follows; `done_o` fires; `aborted_o` = 1; `step_cnt_o` = 2.
- Spurious inputs:
  - Stimulus: `wb_done_i` in ISSUE_HY and in IDLE; `start_i` during WAIT_EZ.
  - Expected: no state change and no extra flags. The target and `step_cnt_o` are unchanged.
- Reset mid-run:
  - Stimulus: assert `RST_N` low in WAIT_SRC of step 1.
  - Expected: all outputs 0 immediately. After release, FSM is in IDLE and no flag appears without a new `start_i`.
- Back-to-back runs:
  - Stimulus: `start_i` in the cycle `done_o` is high, then again the cycle after.
  - Expected: the first is ignored; the second is accepted, with `calc_Hy_flg_o` high one cycle later and `step_cnt_o` cleared to 0.
